// File: rtl/div_seq.sv
// Iterative RV32M divider: DIV/DIVU/REM/REMU via a 32-step restoring loop,
// with one-cycle bypass for divide-by-zero and signed overflow.
module div_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            div_start_i,
  input  logic [1:0]      div_op_sel_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] rs1_rd_data_i,
  input  logic [XLEN-1:0] rs2_rd_data_i,
  output logic            div_busy_o,
  output logic            div_done_o,
  output logic [XLEN-1:0] div_data_o
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic              sgn_a_q, sgn_a_d;
  logic              sgn_b_q, sgn_b_d;
  logic              pend_q, pend_d;
  logic [XLEN-1:0]   pend_res_q, pend_res_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   data_q, data_d;

  // Operand preparation at start: op[0]=1 means unsigned, op[1]=1 selects remainder
  logic              in_signed_c;
  logic              in_sgn_a_c, in_sgn_b_c;
  logic [XLEN-1:0]   in_mag_a_c, in_mag_b_c;
  logic              in_div0_c, in_ovf_c;

  assign in_signed_c = ~div_op_sel_i[0];
  assign in_sgn_a_c  = in_signed_c & rs1_rd_data_i[XLEN-1];
  assign in_sgn_b_c  = in_signed_c & rs2_rd_data_i[XLEN-1];
  assign in_mag_a_c  = in_sgn_a_c ? -rs1_rd_data_i : rs1_rd_data_i;
  assign in_mag_b_c  = in_sgn_b_c ? -rs2_rd_data_i : rs2_rd_data_i;
  assign in_div0_c   = (rs2_rd_data_i == '0);
  assign in_ovf_c    = in_signed_c && (rs1_rd_data_i == MIN_NEG) && (rs2_rd_data_i == '1);

  // One restoring step: shift in next dividend bit, trial-subtract the divisor
  logic [XLEN:0]     shifted_c, diff_c;
  assign shifted_c = {rem_q, quo_q[XLEN-1]};
  assign diff_c    = shifted_c - {1'b0, dvs_q};

  // Sign correction of the final quotient and remainder
  logic [XLEN-1:0]   q_fix_c, r_fix_c;
  assign q_fix_c = (sgn_a_q ^ sgn_b_q) ? -quo_q : quo_q;
  assign r_fix_c = sgn_a_q ? -rem_q : rem_q;

  // Next-state and datapath update; flush overrides everything
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    sgn_a_d    = sgn_a_q;
    sgn_b_d    = sgn_b_q;
    pend_d     = 1'b0;
    pend_res_d = pend_res_q;
    done_d     = 1'b0;
    data_d     = data_q;

    if (flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pend_q) begin
            done_d = 1'b1;
            data_d = pend_res_q;
          end else if (div_start_i) begin
            op_d    = div_op_sel_i;
            sgn_a_d = in_sgn_a_c;
            sgn_b_d = in_sgn_b_c;
            quo_d   = in_mag_a_c;
            dvs_d   = in_mag_b_c;
            if (in_div0_c) begin
              pend_d     = 1'b1;
              pend_res_d = div_op_sel_i[1] ? rs1_rd_data_i : '1;
            end else if (in_ovf_c) begin
              pend_d     = 1'b1;
              pend_res_d = div_op_sel_i[1] ? '0 : MIN_NEG;
            end else begin
              rem_d   = '0;
              cnt_d   = CNT_W'(XLEN - 1);
              state_d = CALC;
            end
          end
        end
        CALC: begin
          if (!diff_c[XLEN]) begin
            rem_d = diff_c[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = shifted_c[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          if (cnt_q == '0) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        FIX: begin
          done_d  = 1'b1;
          data_d  = op_q[1] ? r_fix_c : q_fix_c;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy_d = (state_d != IDLE);

  // State, working registers and registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      op_q       <= '0;
      sgn_a_q    <= 1'b0;
      sgn_b_q    <= 1'b0;
      pend_q     <= 1'b0;
      pend_res_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      sgn_a_q    <= sgn_a_d;
      sgn_b_q    <= sgn_b_d;
      pend_q     <= pend_d;
      pend_res_q <= pend_res_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      data_q     <= data_d;
    end
  end

  assign div_busy_o = busy_q;
  assign div_done_o = done_q;
  assign div_data_o = data_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: stimulus pushes expected results, a monitor
// pops and compares on every done pulse; timing is checked by the stimulus side.
module tb_div_seq;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op_sel;
  logic        flush;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] data;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_data = '0;
  logic        prev_done = 1'b0;

  div_seq #(.XLEN(32)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .div_start_i  (start),
    .div_op_sel_i (op_sel),
    .flush_i      (flush),
    .rs1_rd_data_i(rs1),
    .rs2_rd_data_i(rs2),
    .div_busy_o   (busy),
    .div_done_o   (done),
    .div_data_o   (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: compare every done pulse against the oldest expected result
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done = 1'b0;
    end else begin
      if (done) begin
        check("done_not_consecutive", 32'(prev_done), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          check("result", data, exp_q.pop_front());
        end
      end
      prev_done = done;
    end
  end

  // Issue one op from the current cycle (caller sits just after a rising edge).
  // lat: cycle index after the start edge in which done is expected (34 or 2).
  // poke_at: cycle in which to pulse an unrelated start. abort_at: cycle to
  // abort by flush (use_rst=0) or reset (use_rst=1); no result is expected then.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input int poke_at,
                        input int abort_at, input bit use_rst);
    int cycles;
    int busy_cnt;
    bit got;
    start  = 1'b1;
    op_sel = op;
    rs1    = a;
    rs2    = b;
    if (abort_at == 0) exp_q.push_back(exp);
    @(posedge clk); #1;
    start  = 1'b0;
    rs1    = 32'hDEAD_BEEF;
    rs2    = 32'h0000_0003;
    op_sel = OP_REM;
    cycles = 1;
    busy_cnt = 0;
    got = 1'b0;
    while (cycles < 60) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      if (abort_at != 0 && cycles == abort_at) begin
        if (use_rst) begin
          rst_n = 1'b0;
          #1;
          check("rst_mid_busy", 32'(busy), 32'd0);
          check("rst_mid_done", 32'(done), 32'd0);
          check("rst_mid_data", data, 32'd0);
          rst_n = 1'b1;
          last_data = '0;
        end else begin
          flush = 1'b1;
          @(posedge clk); #1;
          flush = 1'b0;
          check("flush_busy", 32'(busy), 32'd0);
          check("flush_data_kept", data, last_data);
        end
        return;
      end
      if (poke_at != 0 && cycles == poke_at) begin
        start = 1'b1;
        rs1   = 32'd1000;
        rs2   = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    check("done_latency", 32'(cycles), 32'(lat));
    check("busy_cycles", 32'(busy_cnt), (lat == 34) ? 32'd33 : 32'd0);
    check("busy_low_in_done", 32'(busy), 32'd0);
    last_data = exp;
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    op_sel = '0;
    rs1    = '0;
    rs2    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_data", data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Normal path, back-to-back from each done cycle
    run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 0, 0, 1'b0);
    run_op(OP_REMU, 32'd100, 32'd7, 32'd2, 34, 0, 0, 1'b0);
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0, 0, 1'b0);
    run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0, 0, 1'b0);
    run_op(OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 34, 0, 0, 1'b0);

    // Divide by zero and signed overflow bypass
    run_op(OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 2, 0, 0, 1'b0);
    run_op(OP_REMU, 32'd5, 32'd0, 32'd5, 2, 0, 0, 1'b0);
    run_op(OP_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 2, 0, 0, 1'b0);
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 0, 0, 1'b0);
    run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, 0, 0, 1'b0);
    run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, 0, 0, 1'b0);

    // Start pulses during CALC are ignored
    run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 5, 0, 1'b0);
    run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 20, 0, 1'b0);

    // Flush at edge n+10, new start sampled at edge n+11
    run_op(OP_DIVU, 32'd1000, 32'd3, 32'd0, 34, 0, 10, 1'b0);
    run_op(OP_DIV,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34, 0, 0, 1'b0);
    run_op(OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 34, 0, 0, 1'b0);

    // Reset mid-operation
    run_op(OP_DIVU, 32'd1000, 32'd3, 32'd0, 34, 0, 5, 1'b1);
    @(posedge clk); #1;
    run_op(OP_REM,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34, 0, 0, 1'b0);

    // Flush and start in the same cycle: start is dropped
    @(posedge clk); #1;
    start  = 1'b1;
    flush  = 1'b1;
    op_sel = OP_DIVU;
    rs1    = 32'd50;
    rs2    = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b0;
    check("flush_start_busy", 32'(busy), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("flush_start_data", data, last_data);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
